div_seq_ctrl: RTL and testbench

//   Multi-cycle sequencer for unsigned 8-bit division (restoring algorithm) in the ALU.

---
 rtl/div_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_div_seq_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/div_seq_ctrl.sv
// Sequential restoring divider for the ALU: one quotient bit per clock.
// Reuses a shared 8-bit subtractor; divide-by-zero short-circuits to FIN.

// 8-bit subtractor: diff = a - b (two's complement add)
module div_sub8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] diff
);
    // combinational difference
    assign diff = a + ~b + 8'd1;
endmodule

module div_seq_ctrl #(
    parameter int          WIDTH     = 8,
    parameter logic [7:0]  ZERO_QUOT = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state, state_n;
    logic [2:0]       cnt, cnt_n;
    logic [WIDTH-1:0] p_q, p_n;
    logic [WIDTH-1:0] q_q, q_n;
    logic [WIDTH-1:0] dvs_q, dvs_n;
    logic [WIDTH-1:0] quot_n, rem_n;
    logic             dbz_n;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] diff;
    logic             ge;
    logic [WIDTH-1:0] p_step, q_step;

    div_sub8 u_sub (
        .a    (t[WIDTH-1:0]),
        .b    (dvs_q),
        .diff (diff)
    );

    // one restoring step; P < divisor keeps T - divisor within 8 bits
    always_comb begin
        t      = {p_q, q_q[WIDTH-1]};
        ge     = (t >= {1'b0, dvs_q});
        p_step = ge ? diff : t[WIDTH-1:0];
        q_step = {q_q[WIDTH-2:0], ge};
    end

    // next state, datapath and result updates
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        p_n     = p_q;
        q_n     = q_q;
        dvs_n   = dvs_q;
        quot_n  = quotient;
        rem_n   = remainder;
        dbz_n   = div_by_zero;
        unique case (state)
            IDLE: begin
                if (start) begin
                    dvs_n = divisor;
                    dbz_n = 1'b0;
                    p_n   = '0;
                    q_n   = dividend;
                    if (divisor != '0) begin
                        state_n = ITER;
                        cnt_n   = 3'd7;
                    end else begin
                        state_n = FIN;
                        quot_n  = ZERO_QUOT;
                        rem_n   = dividend;
                        dbz_n   = 1'b1;
                    end
                end
            end
            ITER: begin
                p_n   = p_step;
                q_n   = q_step;
                cnt_n = cnt - 3'd1;
                if (cnt == 3'd0) begin
                    state_n = FIN;
                    quot_n  = q_step;
                    rem_n   = p_step;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // state, datapath and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            p_q         <= '0;
            q_q         <= '0;
            dvs_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            p_q         <= p_n;
            q_q         <= q_n;
            dvs_q       <= dvs_n;
            quotient    <= quot_n;
            remainder   <= rem_n;
            div_by_zero <= dbz_n;
            busy        <= (state_n != IDLE);
            done        <= (state_n == FIN);
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: countdown/arithmetic model checked every cycle,
// plus directed literal expectations and a random invariant sweep.
module tb_div_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;

    int pass_cnt = 0;
    int total_cnt = 0;

    div_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    // model: cycles left in the current operation, results as integers
    int         m_left;
    logic [7:0] m_q, m_r, pend_q, pend_r;
    logic       m_dbz;

    // reference behaviour: 9 busy cycles (1 on /0), results shown at done
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_q    = 0;
            m_r    = 0;
            m_dbz  = 0;
        end else if (m_left == 0) begin
            if (start) begin
                m_dbz = 0;
                if (divisor == 0) begin
                    m_left = 1;
                    m_q    = 8'hFF;
                    m_r    = dividend;
                    m_dbz  = 1;
                end else begin
                    m_left = 9;
                    pend_q = dividend / divisor;
                    pend_r = dividend % divisor;
                end
            end
        end else begin
            m_left = m_left - 1;
            if (m_left == 1 && !m_dbz) begin
                m_q = pend_q;
                m_r = pend_r;
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        check("busy", busy, m_left != 0);
        check("done", done, m_left == 1);
        check("quotient", quotient, m_q);
        check("remainder", remainder, m_r);
        check("div_by_zero", div_by_zero, m_dbz);
    end

    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_div(input logic [7:0] a, input logic [7:0] b,
                           output int cyc);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        wait_done(cyc);
    endtask

    initial begin
        int cyc, cyc2, ndone;
        logic [7:0] a, b;

        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_quot", quotient, 0);
        rst = 1'b0;
        @(negedge clk);

        run_div(8'd100, 8'd7, cyc);
        check("100/7 latency", cyc, 9);
        check("100/7 quot", quotient, 14);
        check("100/7 rem", remainder, 2);
        check("100/7 dbz", div_by_zero, 0);
        @(negedge clk);
        check("100/7 busy after", busy, 0);

        run_div(8'd255, 8'd1, cyc);
        check("255/1 quot", quotient, 255);
        check("255/1 rem", remainder, 0);
        @(negedge clk);
        run_div(8'd5, 8'd9, cyc);
        check("5/9 quot", quotient, 0);
        check("5/9 rem", remainder, 5);
        @(negedge clk);
        run_div(8'd255, 8'd255, cyc);
        check("255/255 quot", quotient, 1);
        check("255/255 rem", remainder, 0);
        @(negedge clk);

        run_div(8'd200, 8'd0, cyc);
        check("200/0 latency", cyc, 1);
        check("200/0 quot", quotient, 8'hFF);
        check("200/0 rem", remainder, 200);
        check("200/0 dbz", div_by_zero, 1);
        @(negedge clk);
        check("200/0 busy cycle2", busy, 0);
        check("200/0 dbz held", div_by_zero, 1);

        // start during ITER is ignored
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(negedge clk);
        start = 1'b0;
        cyc = 5;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("ignored latency", cyc, 9);
        check("ignored quot", quotient, 14);
        check("ignored rem", remainder, 2);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("no second done", ndone, 0);

        // reset mid-operation
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst quot", quotient, 0);
        check("rst rem", remainder, 0);
        check("rst dbz", div_by_zero, 0);
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        run_div(8'd9, 8'd3, cyc);
        check("9/3 quot", quotient, 3);
        check("9/3 rem", remainder, 0);
        @(negedge clk);

        // start held high: next accept right after done
        start = 1'b1; dividend = 8'd20; divisor = 8'd3;
        @(negedge clk);
        wait_done(cyc);
        check("held first", cyc, 9);
        @(negedge clk);
        cyc2 = 1;
        while (!done && cyc2 < 20) begin
            @(negedge clk);
            cyc2++;
        end
        check("held spacing", cyc2, 10);
        check("held quot", quotient, 6);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // random sweep of the invariant
        for (int i = 0; i < 1500; i++) begin
            a = 8'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run_div(a, b, cyc);
            check("rnd dbz", div_by_zero, b == 0);
            if (b != 0) begin
                check("rnd invariant",
                      32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                check("rnd rem<div", remainder < b, 1);
            end
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
